// File: rtl/ddr_pkg.sv
// Shared types and command decode for the DDR command responder.
package ddr_pkg;

    typedef enum logic [2:0] {
        CmdNop,
        CmdDesel,
        CmdAct,
        CmdRd,
        CmdWr,
        CmdPre
    } cmd_t;

    typedef enum logic [1:0] {
        BankClosed,
        BankActivating,
        BankOpen,
        BankPrecharging
    } bank_state_t;

    // 000 and 001 (refresh/mode-register slots) are not modelled and fall through to NOP.
    function automatic cmd_t decode_cmd(input logic cs_n, input logic ras_n, input logic cas_n,
                                        input logic we_n, input logic cke);
        cmd_t cmd;
        if (!cke || cs_n) begin
            cmd = CmdDesel;
        end else begin
            case ({ras_n, cas_n, we_n})
                3'b011:  cmd = CmdAct;
                3'b101:  cmd = CmdRd;
                3'b100:  cmd = CmdWr;
                3'b010:  cmd = CmdPre;
                default: cmd = CmdNop;
            endcase
        end
        return cmd;
    endfunction

endpackage

// File: rtl/ddr_bank_fsm.sv
// Per-bank row state machine with tRCD/tRP timers; flags legal and illegal commands.
module ddr_bank_fsm
    import ddr_pkg::*;
#(
    parameter int ROW_W = 4,
    parameter int TRCD  = 2,
    parameter int TRP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  cmd_t             cmd,
    input  logic [ROW_W-1:0] row,
    output logic             busy,
    output logic [ROW_W-1:0] open_row,
    output logic             accept,
    output logic             err
);

    localparam int TMAX = (TRCD > TRP) ? TRCD : TRP;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

    bank_state_t      state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [ROW_W-1:0] row_q, row_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= BankClosed;
            timer_q <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            row_q   <= row_d;
        end
    end

    // Timer is loaded with delay-1 so the bank reaches its settled state exactly delay cycles
    // after the command; a delay of 1 skips the transient state entirely.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        row_d   = row_q;
        accept  = 1'b0;
        err     = 1'b0;
        unique case (state_q)
            BankClosed: begin
                if (sel) begin
                    case (cmd)
                        CmdAct: begin
                            accept = 1'b1;
                            row_d  = row;
                            if (TRCD == 1) begin
                                state_d = BankOpen;
                            end else begin
                                state_d = BankActivating;
                                timer_d = TW'(TRCD - 1);
                            end
                        end
                        CmdPre:        accept = 1'b1;
                        CmdRd, CmdWr:  err = 1'b1;
                        default: ;
                    endcase
                end
            end
            BankActivating: begin
                if (timer_q <= TW'(1)) state_d = BankOpen;
                else                   timer_d = timer_q - 1'b1;
                if (sel && (cmd inside {CmdAct, CmdRd, CmdWr, CmdPre})) err = 1'b1;
            end
            BankOpen: begin
                if (sel) begin
                    case (cmd)
                        CmdRd, CmdWr: accept = 1'b1;
                        CmdPre: begin
                            accept = 1'b1;
                            if (TRP == 1) begin
                                state_d = BankClosed;
                            end else begin
                                state_d = BankPrecharging;
                                timer_d = TW'(TRP - 1);
                            end
                        end
                        CmdAct:  err = 1'b1;
                        default: ;
                    endcase
                end
            end
            BankPrecharging: begin
                if (timer_q <= TW'(1)) state_d = BankClosed;
                else                   timer_d = timer_q - 1'b1;
                if (sel) begin
                    case (cmd)
                        CmdPre:               accept = 1'b1;
                        CmdAct, CmdRd, CmdWr: err = 1'b1;
                        default: ;
                    endcase
                end
            end
            default: state_d = BankClosed;
        endcase
    end

    assign busy     = (state_q == BankActivating) || (state_q == BankPrecharging);
    assign open_row = row_q;

endmodule

// File: rtl/ddr_cmd_responder.sv
// Device-side DDR command responder: decode, bank tracking, word storage, CAS-latency read pipe.
// Define DDR_RESP_ECHK_EN to drive cmd_err on illegal commands; otherwise cmd_err is tied 0.
module ddr_cmd_responder
    import ddr_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int ROW_W     = 4,
    parameter int COL_W     = 4,
    parameter int DATA_W    = 16,
    parameter int CL        = 3,
    parameter int TRCD      = 2,
    parameter int TRP       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cke,
    input  logic              cs_n,
    input  logic              ras_n,
    input  logic              cas_n,
    input  logic              we_n,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_mask,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              ready,
    output logic              cmd_err
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int IDX_W  = BANK_W + ROW_W + COL_W;
    localparam int DEPTH  = 1 << IDX_W;

    cmd_t              cmd;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row_a;
    logic [BANK_W-1:0] bank;
    logic              unused_addr;

    assign cmd         = decode_cmd(cs_n, ras_n, cas_n, we_n, cke);
    assign col         = addr[COL_W-1:0];
    assign row_a       = addr[COL_W+ROW_W-1:COL_W];
    assign bank        = addr[COL_W+ROW_W+:BANK_W];
    assign unused_addr = ^addr[31:IDX_W];

    logic [NUM_BANKS-1:0] busy;
    logic [NUM_BANKS-1:0] accept;
    logic [NUM_BANKS-1:0] err;
    logic [ROW_W-1:0]     open_row [NUM_BANKS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        ddr_bank_fsm #(
            .ROW_W (ROW_W),
            .TRCD  (TRCD),
            .TRP   (TRP)
        ) u_bank (
            .clk      (clk),
            .reset    (reset),
            .sel      (bank == BANK_W'(b)),
            .cmd      (cmd),
            .row      (row_a),
            .busy     (busy[b]),
            .open_row (open_row[b]),
            .accept   (accept[b]),
            .err      (err[b])
        );
    end

    assign ready = ~|busy;

    logic             rd_fire;
    logic             wr_fire;
    logic [IDX_W-1:0] mem_idx;

    assign rd_fire = (cmd == CmdRd) && |accept;
    assign wr_fire = (cmd == CmdWr) && |accept && wr_mask;
    // Address row bits are ignored for column commands; the bank's latched row is used.
    assign mem_idx = {bank, open_row[bank], col};

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_fire) mem[mem_idx] <= wr_data;
    end

    logic              pv_q [CL];
    logic [DATA_W-1:0] pd_q [CL];

    // Data is only shifted alongside a valid bit, so the output stage holds its last word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < CL; k++) begin
                pv_q[k] <= 1'b0;
                pd_q[k] <= '0;
            end
        end else begin
            pv_q[0] <= rd_fire;
            if (rd_fire) pd_q[0] <= mem[mem_idx];
            for (int k = 1; k < CL; k++) begin
                pv_q[k] <= pv_q[k-1];
                if (pv_q[k-1]) pd_q[k] <= pd_q[k-1];
            end
        end
    end

    assign rd_valid = pv_q[CL-1];
    assign rd_data  = pd_q[CL-1];

`ifdef DDR_RESP_ECHK_EN
    logic cmd_err_q;

    always_ff @(posedge clk) begin
        if (!reset) cmd_err_q <= 1'b0;
        else        cmd_err_q <= |err;
    end

    assign cmd_err = cmd_err_q;
`else
    logic unused_err;

    assign cmd_err    = 1'b0;
    assign unused_err = |err;
`endif

endmodule

// File: tb/tb_ddr_cmd_responder.sv
// Directed self-checking bench for ddr_cmd_responder at CL=3, TRCD=2, TRP=2.
module tb_ddr_cmd_responder;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;

`ifdef DDR_RESP_ECHK_EN
    localparam logic [31:0] ERR = 32'd1;
`else
    localparam logic [31:0] ERR = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cke = 1'b1;
    logic        cs_n = 1'b0;
    logic        ras_n = 1'b1;
    logic        cas_n = 1'b1;
    logic        we_n = 1'b1;
    logic [31:0] addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_mask = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        ready;
    logic        cmd_err;

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    ddr_cmd_responder dut (
        .clk      (clk),
        .reset    (reset),
        .cke      (cke),
        .cs_n     (cs_n),
        .ras_n    (ras_n),
        .cas_n    (cas_n),
        .we_n     (we_n),
        .addr     (addr),
        .wr_data  (wr_data),
        .wr_mask  (wr_mask),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .ready    (ready),
        .cmd_err  (cmd_err)
    );

    // Drives one command for one cycle; returns 1 ns after the edge that samples it.
    task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [15:0] d,
                         input logic m, input logic k);
        {cs_n, ras_n, cas_n, we_n} = c;
        addr    = a;
        wr_data = d;
        wr_mask = m;
        cke     = k;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [3:0] c, input logic [31:0] a);
        drive(c, a, 16'h0000, 1'b0, 1'b1);
    endtask

    task automatic nop();
        drive(C_NOP, 32'h0, 16'h0000, 1'b0, 1'b1);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        nop(); nop(); nop();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("rst_cmd_err", 32'(cmd_err), 32'd0);
        reset = 1'b1;

        // Basic write then read on bank0 row5
        op(C_ACT, 32'h050);
        chk("act_ready_low", 32'(ready), 32'd0);
        chk("act_no_err", 32'(cmd_err), 32'd0);
        nop();
        chk("act_ready_back", 32'(ready), 32'd1);
        drive(C_WR, 32'h053, 16'hBEEF, 1'b1, 1'b1);
        op(C_RD, 32'h053);
        nop();
        chk("rd_not_yet", 32'(rd_valid), 32'd0);
        nop();
        chk("rd_valid_cl", 32'(rd_valid), 32'd1);
        chk("rd_data_beef", 32'(rd_data), 32'hBEEF);
        nop();
        chk("rd_valid_drop", 32'(rd_valid), 32'd0);
        chk("rd_data_hold", 32'(rd_data), 32'hBEEF);

        // tRP: ACT one cycle after PRE is rejected, two cycles after is accepted
        op(C_PRE, 32'h000);
        chk("pre_ready_low", 32'(ready), 32'd0);
        op(C_ACT, 32'h070);
        chk("trp_early_err", 32'(cmd_err), ERR);
        op(C_ACT, 32'h070);
        chk("trp_act_ready_low", 32'(ready), 32'd0);
        chk("trp_act_no_err", 32'(cmd_err), 32'd0);
        nop();
        chk("trp_ready_back", 32'(ready), 32'd1);
        drive(C_WR, 32'h07A, 16'h7777, 1'b1, 1'b1);
        op(C_RD, 32'h00A);
        nop(); nop();
        chk("row7_valid", 32'(rd_valid), 32'd1);
        chk("row7_data", 32'(rd_data), 32'h7777);

        // Early READ to an ACTIVATING bank
        op(C_ACT, 32'h250);
        op(C_RD, 32'h253);
        chk("early_rd_err", 32'(cmd_err), ERR);
        nop(); nop();
        chk("early_rd_no_valid", 32'(rd_valid), 32'd0);

        // cke low: ACT ignored, later READ to the still-closed bank is illegal
        drive(C_ACT, 32'h150, 16'h0000, 1'b0, 1'b0);
        chk("cke_ready", 32'(ready), 32'd1);
        chk("cke_no_err", 32'(cmd_err), 32'd0);
        nop();
        op(C_RD, 32'h153);
        chk("cke_rd_err", 32'(cmd_err), ERR);
        nop(); nop();
        chk("cke_rd_no_valid", 32'(rd_valid), 32'd0);

        // Bank interleave with back-to-back reads
        op(C_PRE, 32'h000);
        nop();
        op(C_ACT, 32'h010);
        op(C_ACT, 32'h120);
        drive(C_WR, 32'h013, 16'h1111, 1'b1, 1'b1);
        drive(C_WR, 32'h124, 16'h2222, 1'b1, 1'b1);
        op(C_RD, 32'h013);
        op(C_RD, 32'h124);
        nop();
        chk("ilv_valid0", 32'(rd_valid), 32'd1);
        chk("ilv_data0", 32'(rd_data), 32'h1111);
        nop();
        chk("ilv_valid1", 32'(rd_valid), 32'd1);
        chk("ilv_data1", 32'(rd_data), 32'h2222);
        nop();
        chk("ilv_valid_end", 32'(rd_valid), 32'd0);

        // Masked write is dropped; read data is captured before a later write
        drive(C_WR, 32'h013, 16'hDEAD, 1'b0, 1'b1);
        op(C_RD, 32'h013);
        drive(C_WR, 32'h013, 16'h5555, 1'b1, 1'b1);
        nop();
        chk("mask_capture_data", 32'(rd_data), 32'h1111);
        op(C_RD, 32'h013);
        nop(); nop();
        chk("rewrite_data", 32'(rd_data), 32'h5555);

        // Reset mid-read aborts the read and closes every bank
        op(C_RD, 32'h124);
        reset = 1'b0;
        nop();
        reset = 1'b1;
        nop(); nop();
        chk("abort_no_valid", 32'(rd_valid), 32'd0);
        chk("abort_data_zero", 32'(rd_data), 32'h0);
        chk("abort_ready", 32'(ready), 32'd1);
        op(C_RD, 32'h124);
        chk("abort_bank_closed", 32'(cmd_err), ERR);
        nop();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
